// File: rtl/weight_loader_m_axi_srl_fifo.sv
// First-word-fall-through FIFO: shift-register storage feeding a registered output stage.
// Latency: 1 cycle from push into an empty FIFO to out_valid; sustained 1 word/cycle.
// Backpressure: in_ready is registered (next_level < DEPTH) and does not depend on out_ready.
module weight_loader_m_axi_srl_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int LVL_WIDTH  = 7,
    parameter int AF_THRESH  = 60,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [LVL_WIDTH-1:0]  level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam logic [LVL_WIDTH-1:0] DEPTH_L = LVL_WIDTH'(DEPTH);
    localparam logic [LVL_WIDTH-1:0] AF_L    = LVL_WIDTH'(AF_THRESH);
    localparam logic [LVL_WIDTH-1:0] AE_L    = LVL_WIDTH'(AE_THRESH);
    localparam logic                 AF_RST  = (AF_THRESH == 0);

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  out_valid_q, out_valid_d;
    logic [LVL_WIDTH-1:0]  srl_cnt_q, srl_cnt_d;
    logic [LVL_WIDTH-1:0]  level_q, level_d;
    logic                  in_ready_q, in_ready_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;

    logic                  push, pop, load, srl_has, load_srl, bypass;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] srl_rd_dat;

    assign push     = clk_en & in_valid & in_ready_q;
    assign pop      = clk_en & out_valid_q & out_ready;
    // Output stage refills whenever it is empty or being drained this cycle.
    assign load     = clk_en & (~out_valid_q | pop);
    assign srl_has  = (srl_cnt_q != '0);
    assign load_srl = load & srl_has;
    // With an empty shift register, incoming data goes straight to the output stage.
    assign bypass   = load & ~srl_has & push;
    assign rd_addr  = ADDR_WIDTH'(srl_cnt_q - LVL_WIDTH'(1));

    generate
        if (DEPTH > 1) begin : g_srl
            logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-2];

            // Shift storage up on every accepted write; newest word lands in slot 0.
            always_ff @(posedge clk) begin
                if (push) begin
                    for (int i = DEPTH - 2; i > 0; i--) begin
                        mem_q[i] <= mem_q[i-1];
                    end
                    mem_q[0] <= din;
                end
            end

            assign srl_rd_dat = mem_q[rd_addr];
        end else begin : g_no_srl
            assign srl_rd_dat = '0;
        end
    endgenerate

    // Next-state for output stage, shift-register count, level and flags.
    always_comb begin
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        if (load_srl) begin
            dout_d      = srl_rd_dat;
            out_valid_d = 1'b1;
        end else if (bypass) begin
            dout_d      = din;
            out_valid_d = 1'b1;
        end else if (load) begin
            out_valid_d = 1'b0;
        end
        srl_cnt_d  = srl_cnt_q + LVL_WIDTH'(push & ~bypass) - LVL_WIDTH'(load_srl);
        level_d    = srl_cnt_d + LVL_WIDTH'(out_valid_d);
        in_ready_d = (level_d < DEPTH_L);
        af_d       = (level_d >= AF_L);
        ae_d       = (level_d <= AE_L);
    end

    // State register: reset beats flush; clk_en gates everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            srl_cnt_q   <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b1;
            af_q        <= AF_RST;
            ae_q        <= 1'b1;
        end else if (clk_en) begin
            if (flush) begin
                dout_q      <= '0;
                out_valid_q <= 1'b0;
                srl_cnt_q   <= '0;
                level_q     <= '0;
                in_ready_q  <= 1'b1;
                af_q        <= AF_RST;
                ae_q        <= 1'b1;
            end else begin
                dout_q      <= dout_d;
                out_valid_q <= out_valid_d;
                srl_cnt_q   <= srl_cnt_d;
                level_q     <= level_d;
                in_ready_q  <= in_ready_d;
                af_q        <= af_d;
                ae_q        <= ae_d;
            end
        end
    end

    assign dout         = dout_q;
    assign out_valid    = out_valid_q;
    assign in_ready     = in_ready_q;
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule

// File: tb/tb_weight_loader_m_axi_srl_fifo.sv
// Bench for weight_loader_m_axi_srl_fifo at DEPTH 64, 1 and 2 driven by shared stimulus.
// Each instance has its own queue-based reference; a monitor compares 1 time unit after each edge.
// Directed phases from the test plan followed by a randomized phase with a mid-stream reset.
module tb_weight_loader_m_axi_srl_fifo;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        flush;
    logic        in_valid;
    logic [31:0] din;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL D%0d %s actual=%h required=%h at %0t", d, nm, act, exp, $time);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_inst
            localparam int D  = (gi == 0) ? 64 : ((gi == 1) ? 1 : 2);
            localparam int AF = (gi == 0) ? 60 : D;
            localparam int AE = (gi == 0) ? 4 : 0;
            localparam int LW = $clog2(D + 1);
            localparam int AW = (D > 2) ? $clog2(D - 1) : 1;

            logic          in_ready, out_valid, almost_full, almost_empty;
            logic [31:0]   dout;
            logic [LW-1:0] level;

            weight_loader_m_axi_srl_fifo #(
                .DATA_WIDTH(32), .DEPTH(D), .ADDR_WIDTH(AW), .LVL_WIDTH(LW),
                .AF_THRESH(AF), .AE_THRESH(AE)
            ) dut (
                .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
                .in_valid(in_valid), .in_ready(in_ready), .din(din),
                .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
                .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
            );

            // Reference: a plain queue of accepted words plus the last word shown on dout.
            logic [31:0] sb[$];
            logic [31:0] last_dout = '0;

            always @(posedge clk) begin
                if (reset) begin
                    sb.delete();
                    last_dout = '0;
                end else if (clk_en) begin
                    if (flush) begin
                        sb.delete();
                        last_dout = '0;
                    end else begin
                        bit acc_push;
                        bit acc_pop;
                        acc_push = in_valid && (sb.size() < D);
                        acc_pop  = out_ready && (sb.size() > 0);
                        if (acc_pop) last_dout = sb.pop_front();
                        if (acc_push) sb.push_back(din);
                    end
                end
            end

            always @(posedge clk) begin
                int n;
                #1;
                n = sb.size();
                check(D, "level", 32'(level), 32'(n));
                check(D, "out_valid", 32'(out_valid), 32'(n > 0));
                check(D, "in_ready", 32'(in_ready), 32'(n < D));
                check(D, "almost_full", 32'(almost_full), 32'(n >= AF));
                check(D, "almost_empty", 32'(almost_empty), 32'(n <= AE));
                check(D, "dout", dout, (n > 0) ? sb[0] : last_dout);
            end
        end
    endgenerate

    task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic ce);
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        flush     = fl;
        clk_en    = ce;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; flush = 1'b0;
        in_valid = 1'b0; din = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Idle after reset.
        repeat (5) cyc(0, 0, 0, 0, 1);
        // Single push then pop.
        cyc(1, 32'hA5A5_0001, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // Fill to capacity, attempt a push while full, then drain.
        for (int i = 0; i < 64; i++) cyc(1, 32'(i), 0, 0, 1);
        repeat (2) cyc(1, 32'hDEAD, 0, 0, 1);
        repeat (66) cyc(0, 0, 1, 0, 1);
        // Sustained push+pop at level 10.
        for (int i = 0; i < 10; i++) cyc(1, 32'(1000 + i), 0, 0, 1);
        for (int i = 0; i < 100; i++) cyc(1, 32'(2000 + i), 1, 0, 1);
        cyc(0, 0, 0, 1, 1);
        // Flush with simultaneous push and pop, then a fresh push.
        for (int i = 0; i < 20; i++) cyc(1, 32'(3000 + i), 0, 0, 1);
        cyc(1, 32'hFFFF_0000, 1, 1, 1);
        cyc(1, 32'h1234, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        // Level 5 then clk_en held low with toggling controls.
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 32'(4000 + i), 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(i[0], $urandom, ~i[0], i[1], 0);
        repeat (6) cyc(0, 0, 1, 0, 1);
        // Randomized traffic; fill-biased then drain-biased, with one mid-stream reset.
        for (int k = 0; k < 1500; k++) begin
            reset = (k == 700);
            cyc($urandom_range(0, 3) != 0, $urandom,
                (k < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0);
        end
        reset = 1'b0;
        repeat (80) cyc(0, 0, 1, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
